// File: rtl/jtag_debug_cmd_sync_if.sv
// ---------------------------------------------------------------------------
// jtag_debug_cmd_sync_if
// Bundles the debug-bridge signals between the TCK-side capture logic / core
// (master) and the system-clock command synchroniser (slave).
//   master drives : ir_in, sr, vs_uir, vs_udr, core_busy, clr_overrun
//   slave drives  : jdo, ir_q, ir_update, take_action, take_no_action,
//                   cmd_pending, overrun
// ---------------------------------------------------------------------------
interface jtag_debug_cmd_sync_if #(
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38
);
  localparam int unsigned NUM_IR = 1 << IR_W;

  logic [IR_W-1:0]   ir_in;
  logic [DR_W-1:0]   sr;
  logic              vs_uir;
  logic              vs_udr;
  logic              core_busy;
  logic              clr_overrun;

  logic [DR_W-1:0]   jdo;
  logic [IR_W-1:0]   ir_q;
  logic              ir_update;
  logic [NUM_IR-1:0] take_action;
  logic [NUM_IR-1:0] take_no_action;
  logic              cmd_pending;
  logic              overrun;

  modport master (
    output ir_in, sr, vs_uir, vs_udr, core_busy, clr_overrun,
    input  jdo, ir_q, ir_update, take_action, take_no_action, cmd_pending, overrun
  );

  modport slave (
    input  ir_in, sr, vs_uir, vs_udr, core_busy, clr_overrun,
    output jdo, ir_q, ir_update, take_action, take_no_action, cmd_pending, overrun
  );
endinterface

// File: rtl/jtag_debug_cmd_sync.sv
// ---------------------------------------------------------------------------
// jtag_debug_cmd_sync
// System-clock half of the CPU debug-module JTAG bridge. Synchronises the
// virtual-JTAG update-IR / update-DR levels into clk, captures IR and the
// shift register, and issues one-hot take_action / take_no_action strobes,
// holding commands back while the core is busy.
// Ports:
//   clk      system clock
//   reset_n  synchronous active-low reset
//   bus      jtag_debug_cmd_sync_if.slave (levels, data, busy/clear in;
//            jdo, ir_q, ir_update, strobes, cmd_pending, overrun out)
// Parameters: IR_W, DR_W, ACT_BIT (< DR_W), SYNC_STAGES (>= 2).
// ---------------------------------------------------------------------------
module jtag_debug_cmd_sync #(
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DR_W        = 38,
  parameter int unsigned ACT_BIT     = 37,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic                  clk,
  input logic                  reset_n,
  jtag_debug_cmd_sync_if.slave bus
);

  typedef enum logic [1:0] {
    CmdIdle,
    CmdPending,
    CmdDefer
  } cmdState_e;

  logic [SYNC_STAGES-1:0] uirSync_q;
  logic [SYNC_STAGES-1:0] udrSync_q;
  logic [SYNC_STAGES-1:0] syncValid_q;
  logic                   uirPrev_q;
  logic                   udrPrev_q;
  logic                   uirEdge;
  logic                   udrEdge;

  cmdState_e              state_q;
  cmdState_e              state_d;
  logic                   capture;
  logic                   fire;
  logic                   overSet;

  logic [DR_W-1:0]        jdo_q;
  logic [IR_W-1:0]        cmdIr_q;
  logic [IR_W-1:0]        irReg_q;
  logic                   irUpdate_q;
  logic                   fire_q;
  logic                   overrun_q;

  // Level synchronisers. syncValid_q fills with ones after reset so the
  // "previous" registers stay at 1 until the chain holds real samples; a
  // level already high at reset release therefore never looks like an edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      uirSync_q   <= '0;
      udrSync_q   <= '0;
      syncValid_q <= '0;
      uirPrev_q   <= 1'b1;
      udrPrev_q   <= 1'b1;
    end else begin
      uirSync_q   <= {uirSync_q[SYNC_STAGES-2:0], bus.vs_uir};
      udrSync_q   <= {udrSync_q[SYNC_STAGES-2:0], bus.vs_udr};
      syncValid_q <= {syncValid_q[SYNC_STAGES-2:0], 1'b1};
      uirPrev_q   <= syncValid_q[SYNC_STAGES-1] ? uirSync_q[SYNC_STAGES-1] : 1'b1;
      udrPrev_q   <= syncValid_q[SYNC_STAGES-1] ? udrSync_q[SYNC_STAGES-1] : 1'b1;
    end
  end

  assign uirEdge = uirSync_q[SYNC_STAGES-1] & ~uirPrev_q;
  assign udrEdge = udrSync_q[SYNC_STAGES-1] & ~udrPrev_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CmdIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // CmdDefer covers an update-DR that lands on the cycle a pending strobe is
  // released: the old command fires with the old jdo, and the new one is
  // captured one cycle later so it cannot corrupt the strobe being issued.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    fire    = 1'b0;
    overSet = 1'b0;
    case (state_q)
      CmdIdle: begin
        if (udrEdge) begin
          capture = 1'b1;
          if (bus.core_busy) state_d = CmdPending;
          else               fire    = 1'b1;
        end
      end
      CmdPending: begin
        if (!bus.core_busy) begin
          fire    = 1'b1;
          state_d = udrEdge ? CmdDefer : CmdIdle;
        end else if (udrEdge) begin
          capture = 1'b1;
          overSet = 1'b1;
        end
      end
      CmdDefer: begin
        capture = 1'b1;
        if (bus.core_busy) begin
          state_d = CmdPending;
        end else begin
          fire    = 1'b1;
          state_d = CmdIdle;
        end
      end
      default: state_d = CmdIdle;
    endcase
  end

  // Overrun set has priority over a coincident clear.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      jdo_q      <= '0;
      cmdIr_q    <= '0;
      irReg_q    <= '0;
      irUpdate_q <= 1'b0;
      fire_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      if (uirEdge) irReg_q <= bus.ir_in;
      irUpdate_q <= uirEdge;
      if (capture) begin
        jdo_q   <= bus.sr;
        cmdIr_q <= bus.ir_in;
      end
      fire_q <= fire;
      if (overSet)              overrun_q <= 1'b1;
      else if (bus.clr_overrun) overrun_q <= 1'b0;
    end
  end

  // Strobes decode the registered command, so they see jdo as it reads in
  // the strobe cycle itself.
  always_comb begin
    bus.take_action    = '0;
    bus.take_no_action = '0;
    if (fire_q) begin
      if (jdo_q[ACT_BIT]) bus.take_action[cmdIr_q]    = 1'b1;
      else                bus.take_no_action[cmdIr_q] = 1'b1;
    end
  end

  assign bus.jdo         = jdo_q;
  assign bus.ir_q        = irReg_q;
  assign bus.ir_update   = irUpdate_q;
  assign bus.cmd_pending = (state_q == CmdPending);
  assign bus.overrun     = overrun_q;

endmodule

// File: doc/jtag_debug_cmd_sync.md
Name: jtag_debug_cmd_sync

Overview:
- System-clock half of the CPU debug-module JTAG bridge, parametrised successor of the fixed 2-bit-IR / 38-bit-DR sysclk stage.
- Synchronises the virtual-JTAG update-IR and update-DR levels into clk and captures the TCK-domain shift register and IR.
- Decodes each captured command into one-hot take_action / take_no_action strobes.
- Adds a core-busy hold-off, so a command arriving while the core is busy is held pending. Also adds a sticky overrun flag.

Parameters:
- IR_W, 2, virtual IR width; strobe vector width NUM_IR = 2**IR_W.
- DR_W, 38, shift-register and jdo width.
- ACT_BIT, 37, jdo bit that selects action (1) or no-action (0); must be < DR_W.
- SYNC_STAGES, 2, flops in each level synchroniser; must be >= 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous active-low reset.
- ir_in  in  IR_W  TCK-domain IR value; stable while vs_uir/vs_udr are high.
- sr  in  DR_W  TCK-domain shift register; stable while vs_udr is high.
- vs_uir  in  1  async level, update-IR state.
- vs_udr  in  1  async level, update-DR state.
- core_busy  in  1  core cannot accept a debug command this cycle.
- clr_overrun  in  1  clears the overrun flag.
- jdo  out  DR_W  captured command data.
- ir_q  out  IR_W  last IR captured on update-IR.
- ir_update  out  1  one-cycle pulse when ir_q is loaded.
- take_action  out  NUM_IR  one-hot one-cycle strobe.
- take_no_action  out  NUM_IR  one-hot one-cycle strobe.
- cmd_pending  out  1  command captured, strobe not yet issued.
- overrun  out  1  sticky flag: a new update-DR arrived while a command was pending.

Behaviour:
- Reset is synchronous and active-low on clk; all logic is in the single clk domain. While reset_n=0:
  - All outputs are 0 (jdo, ir_q, strobes, ir_update, cmd_pending, overrun).
  - The synchroniser chains clear to 0.
  - The edge-detect "previous" registers set to 1. Consequently a level already high at reset release produces no edge; only a later low-to-high transition fires.
- Edge detect:
  - udr_edge = sync_udr & ~prev_udr; uir_edge is formed the same way.
  - If the level is first sampled high at clock edge k, the edge is seen and acted on at clock edge k+SYNC_STAGES. The result is visible in the following cycle, giving latency SYNC_STAGES+1 cycles from the sampling edge to the registered outputs.
- Update-IR: on a uir_edge, ir_q <= ir_in and ir_update pulses for 1 cycle.
- Update-DR: on a udr_edge, jdo <= sr and cmd_ir <= ir_in (internal) are captured in the same cycle. Then:
  - If core_busy=0 and no command is pending, the strobe is issued immediately, in the same cycle as the capture.
  - Otherwise cmd_pending <= 1.
- Pending command: while cmd_pending=1 and core_busy=0, the strobe is issued and cmd_pending <= 0 on that edge.
- Strobe decode: take_action[i] = (cmd_ir==i) & jdo[ACT_BIT]; take_no_action[i] = (cmd_ir==i) & ~jdo[ACT_BIT]. Exactly one bit across both vectors is high, for exactly one cycle per accepted command. The strobe decode uses jdo as it reads during the strobe cycle.
- Overrun: a udr_edge while cmd_pending=1 sets overrun, overwrites jdo and cmd_ir with the newer command, and keeps cmd_pending=1. The older command is dropped and exactly one strobe (the newer command) is issued later.
- A udr_edge coinciding with the issue of a pending strobe is not an overrun. The pending strobe issues with the old jdo, and the new command is captured the next cycle. That capture is either issued immediately (if core_busy=0) or becomes pending.
- overrun stays set until a cycle with clr_overrun=1. If set and clear coincide, set wins.
- Simultaneous uir_edge and udr_edge: both take effect. The DR command uses the same-cycle ir_in, not the old ir_q.
- jdo holds its value between commands. Strobes and ir_update are 0 in every other cycle.

Test Plan:
- Reset release with vs_udr=1 held, SYNC_STAGES=2: then raise vs_uir -> no take_* strobe; ir_update pulses 1 cycle, 3 cycles after the sampling edge.
- ir_in=2'b01, sr=38'h20_0000_1234 (bit37=1), vs_udr pulse, core_busy=0 -> jdo=38'h20_0000_1234; take_action=4'b0010 for 1 cycle, 3 cycles after the sampling edge; take_no_action=0.
- ir_in=2'b11, sr bit37=0, core_busy=1 for 10 cycles -> cmd_pending=1 and no strobe while busy; take_no_action=4'b1000 exactly 1 cycle after the first core_busy=0 edge; cmd_pending clears.
- Two udr pulses (sr=38'h1, then 38'h2, ir 00) while busy -> overrun=1; one strobe with jdo=38'h2. Then clr_overrun=1 for 1 cycle -> overrun=0.
- udr edge coinciding with the release of a pending strobe -> old strobe first, new strobe next cycle, overrun stays 0.
- Parameter sweep IR_W=3, DR_W=45, ACT_BIT=44, SYNC_STAGES=3, ir_in=3'd6 -> take_action=8'h40 with 4-cycle latency.
